// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================
// muldiv_unit_pkg : shared types for the multiply/divide unit
// Revision: 1.0
// ============================================================
package muldiv_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    localparam int DIV_ITERS = 32;

    function automatic word_t abs_word(input word_t v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_iter.sv
`default_nettype none
// ============================================================
// muldiv_unit_div_iter : one radix-2 restoring division step
// Revision: 1.0
// ============================================================
module muldiv_unit_div_iter
    import muldiv_unit_pkg::*;
(
    input  logic [63:0] rq_in,
    input  word_t       divisor,
    output logic [63:0] rq_out
);

    logic [32:0] w_partial;
    logic [32:0] w_diff;

    // Upper half is the running remainder, lower half shifts in quotient bits.
    always_comb begin
        w_partial = rq_in[63:31];
        w_diff    = w_partial - {1'b0, divisor};
        if (!w_diff[32]) begin
            rq_out = {w_diff[31:0], rq_in[30:0], 1'b1};
        end else begin
            rq_out = {rq_in[62:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================
// muldiv_unit : multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO
// Revision: 1.0
// ============================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int          MUL_LAT    = 3,
    parameter logic [31:0] RESET_HILO = 32'h0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  muldiv_op_t op,
    input  word_t      a,
    input  word_t      b,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output word_t      hi,
    output word_t      lo
);

    md_state_t   r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_rq;
    word_t       r_divisor;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [63:0] r_pipe [MUL_LAT];

    logic        w_accept;
    logic        w_mul_signed;
    logic        w_div_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_product;
    logic [63:0] w_rq_next;

    assign w_accept     = start & ~busy & ~flush;
    assign w_mul_signed = (op == MD_MULT);
    assign w_div_signed = (op == MD_DIV);
    // Low 64 bits of the product of sign- or zero-extended operands.
    assign w_a_ext      = {{32{w_mul_signed & a[31]}}, a};
    assign w_b_ext      = {{32{w_mul_signed & b[31]}}, b};
    assign w_product    = w_a_ext * w_b_ext;

    muldiv_unit_div_iter u_div_iter (
        .rq_in   (r_rq),
        .divisor (r_divisor),
        .rq_out  (w_rq_next)
    );

    always_ff @(posedge clk) begin
        if (w_accept && (op == MD_MULT || op == MD_MULTU)) begin
            r_pipe[0] <= w_product;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= RESET_HILO;
            lo      <= RESET_HILO;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            MD_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            MD_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            MD_MULT, MD_MULTU: begin
                                r_state <= ST_MUL;
                                r_cnt   <= 6'd0;
                                busy    <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_rq      <= {32'h0, w_div_signed ? abs_word(a) : a};
                                r_divisor <= w_div_signed ? abs_word(b) : b;
                                r_q_neg   <= w_div_signed & (a[31] ^ b[31]);
                                r_r_neg   <= w_div_signed & a[31];
                                r_state   <= ST_DIV;
                                r_cnt     <= 6'd0;
                                busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt == 6'(MUL_LAT - 1)) begin
                        {hi, lo} <= r_pipe[MUL_LAT-1];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_rq <= w_rq_next;
                        if (r_cnt == 6'(DIV_ITERS - 1)) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        lo      <= r_q_neg ? (~r_rq[31:0] + 32'd1) : r_rq[31:0];
                        hi      <= r_r_neg ? (~r_rq[63:32] + 32'd1) : r_rq[63:32];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================
// tb_muldiv_unit : directed + random checks against an arithmetic model
// Revision: 1.0
// ============================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int          MUL_LAT    = 3;
    localparam logic [31:0] RESET_HILO = 32'hA5A5_0F0F;

    logic       clk;
    logic       resetn;
    logic       start;
    muldiv_op_t op;
    word_t      a;
    word_t      b;
    logic       flush;
    logic       busy;
    logic       done;
    word_t      hi;
    word_t      lo;

    int    checks   = 0;
    int    failures = 0;
    word_t m_hi;
    word_t m_lo;

    muldiv_unit #(.MUL_LAT(MUL_LAT), .RESET_HILO(RESET_HILO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // Expected {hi,lo} after an operation, from plain arithmetic.
    function automatic logic [63:0] ref_result(muldiv_op_t o, word_t x, word_t y,
                                               word_t cur_hi, word_t cur_lo);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            MD_MULT: begin
                sp = longint'(sx) * longint'(sy);
                return sp;
            end
            MD_MULTU: begin
                up = 64'(x) * 64'(y);
                return up;
            end
            MD_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            MD_DIV: begin
                if (y == 0) return {x, (sx < 0) ? 32'h1 : 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            MD_MTHI: return {x, cur_lo};
            MD_MTLO: return {cur_hi, x};
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge where done is seen.
    // poke_at>0 pulses an MTHI request for one cycle while the op is in flight.
    task automatic run_op(input muldiv_op_t o, input word_t x, input word_t y, input int poke_at);
        int          lat;
        int          nb;
        int          exp_lat;
        logic [63:0] exp;
        exp     = ref_result(o, x, y, m_hi, m_lo);
        exp_lat = (o == MD_MTHI || o == MD_MTLO) ? 1 :
                  (o == MD_MULT || o == MD_MULTU) ? MUL_LAT + 1 : DIV_ITERS + 2;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 1; nb = 0;
        while (!done && lat < 100) begin
            if (busy) nb++;
            if (lat == poke_at) begin
                start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(nb), 64'(exp_lat - 1));
        check("busy_at_done", 64'(busy), 64'd0);
        check("hi", 64'(hi), 64'(exp[63:32]));
        check("lo", 64'(lo), 64'(exp[31:0]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        muldiv_op_t ro;
        word_t      rx;
        word_t      ry;
        int         done_seen;

        resetn = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'(RESET_HILO));
        check("reset_lo", 64'(lo), 64'(RESET_HILO));
        resetn = 1'b1;
        m_hi = RESET_HILO; m_lo = RESET_HILO;
        @(negedge clk);

        // Directed arithmetic cases, issued back to back.
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(MD_DIVU,  32'd7, 32'd0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0, 0);
        run_op(MD_DIV,   32'd9, 32'd0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Flush mid-divide leaves HI/LO untouched.
        run_op(MD_MTHI, 32'h55, 32'd0, 0);
        run_op(MD_MTLO, 32'h55, 32'd0, 0);
        start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_hi", 64'(hi), 64'h55);
        check("flush_lo", 64'(lo), 64'h55);
        run_op(MD_MTHI, 32'h1234, 32'd0, 0);

        // Flush in the final multiply cycle wins over the write.
        start = 1'b1; op = MD_MULTU; a = 32'd1000; b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (MUL_LAT - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("lastflush_no_done", 64'(done_seen), 64'd0);
        check("lastflush_hilo", {hi, lo}, {m_hi, m_lo});

        // Request while busy is ignored.
        run_op(MD_DIVU, 32'd1000, 32'd33, 5);
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 2);

        // Request together with flush is ignored.
        start = 1'b1; op = MD_MTLO; a = 32'hBAD0_BAD0; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush_done", 64'(done), 64'd0);
        check("startflush_busy", 64'(busy), 64'd0);
        check("startflush_lo", 64'(lo), 64'(m_lo));

        // Reset in the middle of a divide.
        start = 1'b1; op = MD_DIV; a = 32'd12345; b = 32'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hilo", {hi, lo}, {RESET_HILO, RESET_HILO});
        resetn = 1'b1;
        m_hi = RESET_HILO; m_lo = RESET_HILO;
        @(negedge clk);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 30; i++) begin
            ro = muldiv_op_t'($urandom_range(0, 5));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry = $urandom_range(1, 20);
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            if ($urandom_range(0, 9) == 0) rx = 32'h8000_0000;
            run_op(ro, rx, ry, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit in the execute stage, placed beside the ALU.
- Executes MULT, MULTU, DIV and DIVU, and handles MTHI and MTLO writes.
- Owns the architectural HI/LO registers. Its hi/lo outputs feed the ALU operand-a pass-through path for MFHI/MFLO.
- Drives busy into the hazard unit so the pipeline stalls while an operation is in flight.

Parameters:
- MUL_LAT, 3, cycles from multiply acceptance to HI/LO update. Legal range 1..8.
- RESET_HILO, 32'h0, reset value of both HI and LO.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request valid. Sampled only when busy=0.
- op  in  3  muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- a  in  32  rs operand (word_t). For MTHI/MTLO, the value written.
- b  in  32  rt operand (word_t).
- flush  in  1  pipeline flush (exception or eret). Aborts the in-flight op.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO become valid with the new result.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, busy=0, done=0, hi=lo=RESET_HILO, counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX.
- Acceptance: start=1, busy=0, flush=0 at an edge.
- Ignored requests:
  - start with busy=1: ignored. The producer holds the request, since the stall keeps it in the ID/EX register.
  - start and flush in the same cycle: ignored.
- MTHI/MTLO: on acceptance, hi<=a (or lo<=a) at the same edge. State stays IDLE, busy never asserts, done=1 in the following cycle.
- MULT/MULTU, IDLE->MUL:
  - Operands latched; busy=1 from the next cycle.
  - Product computed as a 64-bit signed (MULT) or unsigned (MULTU) product.
  - {hi,lo} written exactly MUL_LAT edges after acceptance. done=1 in the cycle after that write. busy drops in the same cycle as done.
- DIV/DIVU, IDLE->DIV:
  - Signed ops latch operand magnitudes and record the signs of quotient and remainder.
  - Radix-2 restoring division: 32 iterations, one per cycle, using a 64-bit remainder/quotient shift register.
  - DIV->FIX after 32 iterations. FIX applies sign correction and writes lo=quotient, hi=remainder, then returns to IDLE.
  - Total: 33 edges from acceptance to HI/LO write. done and busy behave as for multiply.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Boundaries:
  - Divide by zero, unsigned: lo=32'hFFFF_FFFF, hi=a.
  - Divide by zero, signed: lo=(a<0 ? 32'h1 : 32'hFFFF_FFFF), hi=a. These fall naturally out of the restoring algorithm; the bench checks them.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. No exception.
  - Counter wraps only by returning to IDLE; no 6-bit overflow path.
- flush while busy: abort at that edge. State->IDLE, busy=0 next cycle, HI/LO unchanged, no done.
- flush in the final cycle, where the write would occur at the same edge: flush wins and HI/LO are unchanged.
- hi/lo outputs are registered and change only at the write edges described above.
- Back-to-back ops: a new start is accepted in the cycle done=1, since busy=0 there.

Decomposition:
- Shared package common: muldiv_op_t enum (3 bits), the MD_* constants, DIV_ITERS=32.
- Sub-module div_iter: one restoring step, combinational. Inputs: 64-bit remainder/quotient register and 32-bit divisor. Outputs: next register value. Instantiated once and used each DIV cycle.
- Multiply: a behavioural product registered through a MUL_LAT-deep shift register.

Test Plan:
- Reset then MULT a=32'hFFFF_FFFE (-2), b=3 -> after MUL_LAT+1 cycles: done=1, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. Busy high exactly MUL_LAT cycles.
- MULTU a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV a=-7 (32'hFFFF_FFF9), b=2 -> 33 cycles later lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU 7/0 -> lo=32'hFFFF_FFFF, hi=7.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- Start DIVU 100/7 with hi=lo=0x55, flush on cycle 10 -> busy=0 next cycle, no done, hi=lo=0x55. Then MTHI a=0x1234 -> hi=0x1234 next cycle, busy stays 0.
- start pulsed while busy, and start together with flush -> both ignored. Assert resetn=0 mid-DIV -> hi=lo=RESET_HILO, busy=0.
